// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH bits LSB first, optional parity, stop.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit.
`timescale 1ns/1ps
module uart_rx #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Parity_Error,
   output logic                  Stop_Error
);

   localparam int unsigned BcW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                r_state, w_state_nxt;
   logic [5:0]            r_edge_cnt, r_presc;
   logic                  r_par_en, r_par_typ;
   logic [BcW-1:0]        r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_perr, r_serr, r_done;
   logic [5:0]            w_half;
   logic                  w_last, w_bits_done, w_bit, w_start_det;

   assign w_half      = {1'b0, r_presc[5:1]};
   assign w_start_det = (r_state == StIdle) && !RX_IN;
   assign w_last      = (r_state != StIdle) && (r_edge_cnt == r_presc - 6'd1);
   assign w_bits_done = (r_bit_cnt == BcW'(DATA_WIDTH - 1));

`ifdef UART_RX_MAJORITY_EN
   logic [2:0] r_samp;

   assign w_bit = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_samp <= 3'b000;
      end else if (r_state != StIdle) begin
         if (r_edge_cnt == w_half - 6'd1) r_samp[0] <= RX_IN;
         if (r_edge_cnt == w_half)        r_samp[1] <= RX_IN;
         if (r_edge_cnt == w_half + 6'd1) r_samp[2] <= RX_IN;
      end
   end
`else
   logic r_samp;

   assign w_bit = r_samp;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_samp <= 1'b0;
      end else if ((r_state != StIdle) && (r_edge_cnt == w_half)) begin
         r_samp <= RX_IN;
      end
   end
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:   if (!RX_IN) w_state_nxt = StStart;
         StStart:  if (w_last) w_state_nxt = w_bit ? StIdle : StData;
         StData:   if (w_last && w_bits_done) w_state_nxt = r_par_en ? StParity : StStop;
         StParity: if (w_last) w_state_nxt = StStop;
         StStop:   if (w_last) w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_edge_cnt <= 6'd0;
         r_presc    <= 6'd0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
         r_serr     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // Start-detect edge is bit-edge 0, so the counter resumes at 1
         if (w_start_det) begin
            r_edge_cnt <= 6'd1;
            r_presc    <= Prescale;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_bit_cnt  <= '0;
            r_perr     <= 1'b0;
         end else if ((r_state == StIdle) || w_last) begin
            r_edge_cnt <= 6'd0;
         end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
         end
         if (w_last) begin
            if (r_state == StData) begin
               r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
               r_bit_cnt <= w_bits_done ? '0 : r_bit_cnt + BcW'(1);
            end
            if (r_state == StParity) begin
               r_perr <= (^r_shift) ^ w_bit ^ r_par_typ;
            end
            if (r_state == StStop) begin
               r_serr <= ~w_bit;
               r_done <= 1'b1;
            end
         end
      end
   end

   // Outputs follow one cycle after the frame closes
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         P_DATA       <= '0;
         Data_Valid   <= 1'b0;
         Parity_Error <= 1'b0;
         Stop_Error   <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         if (r_done) begin
            Parity_Error <= r_perr;
            Stop_Error   <= r_serr;
            if (!r_perr && !r_serr) begin
               P_DATA     <= r_shift;
               Data_Valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames, parity/stop errors, glitches, back-to-back, reset.
`timescale 1ns/1ps
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [5:0] presc = 6'd8;
   logic       pen = 1'b0;
   logic       ptyp = 1'b0;
   logic [7:0] pdata;
   logic       dv, perr, serr;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int dv_count = 0;
   int dv_cyc = 0;
   int start_cyc = 0;
   int dv0 = 0;
   logic [7:0] glitch_exp;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .CLK(clk), .RST(rst_n), .RX_IN(rx), .Prescale(presc), .PAR_EN(pen), .PAR_TYP(ptyp),
      .P_DATA(pdata), .Data_Valid(dv), .Parity_Error(perr), .Stop_Error(serr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dv) begin
         dv_count <= dv_count + 1;
         dv_cyc   <= cyc;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Each loop pass drives the line for one bit-edge; called on a falling edge.
   task automatic send_frame(input int p, input logic pe, input logic pt, input logic [7:0] d,
                             input logic pbit, input logic sbit, input int glitch_bit,
                             input logic do_rst, input logic scramble);
      logic [10:0] bits;
      int nb;
      #1;
      dv0 = dv_count;
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      nb = pe ? 11 : 10;
      if (pe) begin
         bits[9] = pbit;
         bits[10] = sbit;
      end else begin
         bits[9] = sbit;
      end
      presc = 6'(p);
      pen = pe;
      ptyp = pt;
      for (int b = 0; b < nb; b++) begin
         for (int j = 0; j < p; j++) begin
            rx = (b == glitch_bit && j == p / 2) ? ~bits[b] : bits[b];
            if (scramble && b == 2 && j == 0) begin
               presc = 6'd32;
               pen = ~pe;
               ptyp = ~pt;
            end
            if (do_rst && b == 5 && j == 2) begin
               #2 rst_n = 1'b0;
               #1;
               check_eq("rst.p_data", 32'(pdata), 32'h0);
               check_eq("rst.dv", 32'(dv), 32'h0);
               check_eq("rst.perr", 32'(perr), 32'h0);
               check_eq("rst.serr", 32'(serr), 32'h0);
               @(negedge clk);
               rst_n = 1'b1;
               rx = 1'b1;
               return;
            end
            @(negedge clk);
            if (b == 0 && j == 0) start_cyc = cyc;
         end
      end
      rx = 1'b1;
      presc = 6'(p);
      pen = pe;
      ptyp = pt;
   endtask

   task automatic expect_frame(input string name, input int exp_dv, input int exp_lat,
                               input logic [7:0] exp_data, input logic exp_pe,
                               input logic exp_se);
      repeat (3) @(negedge clk);
      #1;
      check_eq({name, ".dv_pulses"}, 32'(dv_count - dv0), 32'(exp_dv));
      if (exp_dv == 1) check_eq({name, ".latency"}, 32'(dv_cyc - start_cyc), 32'(exp_lat));
      check_eq({name, ".p_data"}, 32'(pdata), 32'(exp_data));
      check_eq({name, ".perr"}, 32'(perr), 32'(exp_pe));
      check_eq({name, ".serr"}, 32'(serr), 32'(exp_se));
   endtask

   initial begin
      int d0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset.p_data", 32'(pdata), 32'h0);
      check_eq("reset.dv", 32'(dv), 32'h0);
      check_eq("reset.perr", 32'(perr), 32'h0);
      check_eq("reset.serr", 32'(serr), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // P=8, no parity
      send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      expect_frame("a5", 1, 80, 8'hA5, 1'b0, 1'b0);

      // P=16, odd parity: good parity bit, then bad
      send_frame(16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, -1, 1'b0, 1'b0);
      expect_frame("3c_odd", 1, 176, 8'h3C, 1'b0, 1'b0);
      send_frame(16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      expect_frame("3c_bad_par", 0, 0, 8'h3C, 1'b1, 1'b0);

      // Low stop bit, then recovery
      send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      expect_frame("stop_err", 0, 0, 8'h3C, 1'b0, 1'b1);
      send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      expect_frame("55", 1, 80, 8'h55, 1'b0, 1'b0);

      // Two-cycle false start; a real start exactly 8 cycles later must be taken
      #1;
      dv0 = dv_count;
      presc = 6'd8;
      pen = 1'b0;
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      check_eq("false_start.dv", 32'(dv_count - dv0), 32'h0);
      check_eq("false_start.p_data", 32'(pdata), 32'h55);
      check_eq("false_start.serr", 32'(serr), 32'h0);
      send_frame(8, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      expect_frame("c3_even", 1, 88, 8'hC3, 1'b0, 1'b0);

      // Mid-bit glitch on data bit 3 of 0x00
`ifdef UART_RX_MAJORITY_EN
      glitch_exp = 8'h00;
`else
      glitch_exp = 8'h08;
`endif
      send_frame(8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b0, 1'b0);
      expect_frame("glitch", 1, 80, glitch_exp, 1'b0, 1'b0);

      // Back-to-back, with configuration scrambled mid-frame on the first
      #1;
      d0 = dv_count;
      send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, -1, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      check_eq("b2b.first_dv", 32'(dv), 32'h1);
      check_eq("b2b.first_data", 32'(pdata), 32'h5A);
      send_frame(8, 1'b0, 1'b0, 8'hA6, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      expect_frame("b2b.second", 1, 80, 8'hA6, 1'b0, 1'b0);
      check_eq("b2b.total_dv", 32'(dv_count - d0), 32'h2);

      // Reset mid-frame with nonzero outputs present
      send_frame(8, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      expect_frame("7e", 1, 80, 8'h7E, 1'b0, 1'b0);
      send_frame(8, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      expect_frame("pre_rst_stop", 0, 0, 8'h7E, 1'b0, 1'b1);
      send_frame(8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, -1, 1'b1, 1'b0);
      repeat (16) @(negedge clk);
      #1;
      check_eq("rst.no_dv", 32'(dv_count - dv0), 32'h0);
      check_eq("rst.held_data", 32'(pdata), 32'h0);
      send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      expect_frame("81", 1, 80, 8'h81, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
